rs_codec_sequencer: RTL and testbench

//  Clocked sequencer for the RS(15,9) GF(16) encode -> channel -> decode path.

---
 rtl/rs_pkg.sv | 23 ++
 rtl/rs_busy_watchdog.sv | 67 ++++++
 rtl/rs_codec_sequencer.sv | 167 ++++++++++++++++
 tb/tb_rs_codec_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants and state encoding for the RS(15,9) GF(16) codec sequencer.
package rs_pkg;

    localparam int SYM_W = 4;               // bits per GF(16) symbol
    localparam int N_SYM = 15;              // codeword length in symbols
    localparam int K_SYM = 9;               // message length in symbols
    localparam int MSG_W = SYM_W * K_SYM;   // 36-bit message bus
    localparam int CW_W  = SYM_W * N_SYM;   // 60-bit codeword bus

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENC_WAIT = 3'd1,
        DEC_GO   = 3'd2,
        DEC_WAIT = 3'd3,
        RESULT   = 3'd4
    } seq_state_t;

    // True for the two states that hand control to the busy watchdog.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == ENC_WAIT) || (s == DEC_WAIT);
    endfunction

endpackage

// File: rtl/rs_busy_watchdog.sv
// Settle window plus bounded busy wait, shared by the encoder and decoder phases.
// After arm, busy is ignored for SETTLE_CYC cycles, then sampled every cycle:
// a low sample pulses done; TIMEOUT_CYC consecutive high samples pulse timeout.
// Both outputs are single-cycle pulses one clock after the deciding sample.
module rs_busy_watchdog #(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic busy,
    output logic done,
    output logic timeout
);

    localparam int unsigned SET_W = (SETTLE_CYC  > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC)    : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic             r_active;
    logic [SET_W-1:0] r_settle;
    logic [TMO_W-1:0] r_busy_cnt;
    logic             r_done;
    logic             r_timeout;

    // Settle countdown, then busy sampling with a consecutive-high counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_settle   <= '0;
            r_busy_cnt <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (arm) begin
            r_active   <= 1'b1;
            r_settle   <= SET_LOAD;
            r_busy_cnt <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (r_active) begin
                if (r_settle != '0) begin
                    r_settle <= r_settle - SET_W'(1);
                end else if (!busy) begin
                    r_done   <= 1'b1;
                    r_active <= 1'b0;
                end else if (TIMEOUT_CYC != 0) begin
                    if (r_busy_cnt == TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_active  <= 1'b0;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + TMO_W'(1);
                    end
                end
            end
        end
    end

    assign done    = r_done;
    assign timeout = r_timeout;

endmodule

// File: rtl/rs_codec_sequencer.sv
// Top-level driver for the RS(15,9) encode -> channel -> decode loopback path.
// Issues toggle-style start requests to external encoder/decoder blocks, injects
// the caller's error pattern, and reports the decoded message with match/timeout
// status and saturating pass/fail statistics.
module rs_codec_sequencer
    import rs_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MSG_W-1:0] msg_in,
    input  logic [CW_W-1:0]  err_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             encodeMessage,
    input  logic             encoderBusy,
    input  logic [CW_W-1:0]  encodedMessage,
    output logic [CW_W-1:0]  recievedWordIn,
    output logic             decodeMessage,
    input  logic             decoderBusy,
    input  logic [MSG_W-1:0] messageRecieved,
    output logic [MSG_W-1:0] out_msg,
    output logic             out_match,
    output logic             out_timeout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic             r_in_ready;
    logic             r_enc_tgl;
    logic             r_dec_tgl;
    logic [MSG_W-1:0] r_msg_q;
    logic [CW_W-1:0]  r_err_q;
    logic [CW_W-1:0]  r_rx_word;
    logic [MSG_W-1:0] r_out_msg;
    logic             r_out_match;
    logic             r_out_timeout;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    logic w_accept;
    logic w_wd_arm;
    logic w_wd_busy;
    logic w_wd_done;
    logic w_wd_timeout;
    logic w_in_wait;
    logic w_out_hs;

    assign w_accept  = in_valid && r_in_ready;
    assign w_in_wait = is_wait_state(r_state);
    assign w_out_hs  = (r_state == RESULT) && out_ready;
    // Re-arm on entry to each WAIT state: accept enters ENC_WAIT, DEC_GO enters DEC_WAIT.
    assign w_wd_arm  = w_accept || (r_state == DEC_GO);
    assign w_wd_busy = (r_state == DEC_WAIT) ? decoderBusy : encoderBusy;

    rs_busy_watchdog #(
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (w_wd_arm),
        .busy    (w_wd_busy),
        .done    (w_wd_done),
        .timeout (w_wd_timeout)
    );

    // Next-state decode for the encode/decode handshake sequence.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_accept)          w_next_state = ENC_WAIT;
            ENC_WAIT: if (w_wd_timeout)      w_next_state = RESULT;
                      else if (w_wd_done)    w_next_state = DEC_GO;
            DEC_GO:                          w_next_state = DEC_WAIT;
            DEC_WAIT: if (w_wd_timeout || w_wd_done) w_next_state = RESULT;
            RESULT:   if (out_ready)         w_next_state = IDLE;
            default:                         w_next_state = IDLE;
        endcase
    end

    // State register; in_ready is registered so it stays low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == IDLE);
        end
    end

    // Input capture, start toggles and the corrupted word sent to the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_tgl <= 1'b0;
            r_dec_tgl <= 1'b0;
            r_msg_q   <= '0;
            r_err_q   <= '0;
            r_rx_word <= '0;
        end else begin
            if (w_accept) begin
                r_msg_q   <= msg_in;
                r_err_q   <= err_in;
                r_enc_tgl <= ~r_enc_tgl;
            end
            // Word is registered one cycle before the decoder toggle so data leads the request.
            if ((r_state == ENC_WAIT) && w_wd_done) begin
                r_rx_word <= encodedMessage ^ r_err_q;
            end
            if (r_state == DEC_GO) begin
                r_dec_tgl <= ~r_dec_tgl;
            end
        end
    end

    // Result capture on leaving either WAIT state; a watchdog abort reports zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_msg     <= '0;
            r_out_match   <= 1'b0;
            r_out_timeout <= 1'b0;
        end else if (w_in_wait && w_wd_timeout) begin
            r_out_msg     <= '0;
            r_out_match   <= 1'b0;
            r_out_timeout <= 1'b1;
        end else if ((r_state == DEC_WAIT) && w_wd_done) begin
            r_out_msg     <= messageRecieved;
            r_out_match   <= (messageRecieved == r_msg_q);
            r_out_timeout <= 1'b0;
        end
    end

    // Saturating statistics, bumped once per consumed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_out_match) begin
                if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            end else begin
                if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign encodeMessage  = r_enc_tgl;
    assign decodeMessage  = r_dec_tgl;
    assign recievedWordIn = r_rx_word;
    assign out_msg        = r_out_msg;
    assign out_match      = r_out_match;
    assign out_timeout    = r_out_timeout;
    assign out_valid      = (r_state == RESULT);
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;

endmodule

// File: tb/tb_rs_codec_sequencer.sv
// Bench for rs_codec_sequencer with behavioural 4-cycle-busy encoder/decoder models.
module tb_rs_codec_sequencer;
    import rs_pkg::*;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned TMO    = 8;
    localparam int unsigned CW     = 3;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic             clk;
    logic             rst_n;
    logic [MSG_W-1:0] msg_in;
    logic [CW_W-1:0]  err_in;
    logic             in_valid;
    logic             in_ready;
    logic             encodeMessage;
    logic             encoderBusy;
    logic [CW_W-1:0]  encodedMessage;
    logic [CW_W-1:0]  recievedWordIn;
    logic             decodeMessage;
    logic             decoderBusy;
    logic [MSG_W-1:0] messageRecieved;
    logic [MSG_W-1:0] out_msg;
    logic             out_match;
    logic             out_timeout;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    pass_cnt;
    logic [CW-1:0]    fail_cnt;

    rs_codec_sequencer #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .msg_in          (msg_in),
        .err_in          (err_in),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .encodeMessage   (encodeMessage),
        .encoderBusy     (encoderBusy),
        .encodedMessage  (encodedMessage),
        .recievedWordIn  (recievedWordIn),
        .decodeMessage   (decodeMessage),
        .decoderBusy     (decoderBusy),
        .messageRecieved (messageRecieved),
        .out_msg         (out_msg),
        .out_match       (out_match),
        .out_timeout     (out_timeout),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pass_cnt        (pass_cnt),
        .fail_cnt        (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural codec models ----------------
    // Systematic stand-in code: message in symbols 0..8, parity in 9..14.
    function automatic logic [CW_W-1:0] enc_model(input logic [MSG_W-1:0] m);
        logic [CW_W-1:0] cw;
        cw = '0;
        cw[MSG_W-1:0] = m;
        for (int j = 0; j < 6; j++)
            cw[MSG_W + 4*j +: 4] = m[4*j +: 4] ^ m[4*(j+3) +: 4] ^ 4'(j + 1);
        return cw;
    endfunction

    // Corrects up to t=3 symbol errors; beyond that returns the corrupted message symbols.
    function automatic logic [MSG_W-1:0] dec_model(input logic [CW_W-1:0] rx, input logic [CW_W-1:0] ref_cw);
        int nerr;
        nerr = 0;
        for (int i = 0; i < N_SYM; i++)
            if (rx[4*i +: 4] != ref_cw[4*i +: 4]) nerr++;
        return (nerr <= 3) ? ref_cw[MSG_W-1:0] : rx[MSG_W-1:0];
    endfunction

    logic [MSG_W-1:0] cur_msg = '0;
    logic enc_hold = 1'b0;
    logic dec_hold = 1'b0;

    logic enc_seen, enc_busy_r;
    int   enc_left;
    logic [CW_W-1:0] enc_cw;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_seen <= 1'b0; enc_busy_r <= 1'b0; enc_left <= 0; enc_cw <= '0;
        end else if (encodeMessage != enc_seen) begin
            enc_seen <= encodeMessage; enc_busy_r <= 1'b1; enc_left <= 3;
            enc_cw <= enc_model(cur_msg);
        end else if (enc_busy_r) begin
            if (enc_left == 0) enc_busy_r <= 1'b0;
            else enc_left <= enc_left - 1;
        end
    end
    assign encoderBusy    = enc_busy_r | enc_hold;
    assign encodedMessage = enc_cw;

    logic dec_seen, dec_busy_r;
    int   dec_left;
    logic [MSG_W-1:0] dec_out;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_seen <= 1'b0; dec_busy_r <= 1'b0; dec_left <= 0; dec_out <= '0;
        end else if (decodeMessage != dec_seen) begin
            dec_seen <= decodeMessage; dec_busy_r <= 1'b1; dec_left <= 3;
            dec_out <= dec_model(recievedWordIn, enc_model(cur_msg));
        end else if (dec_busy_r) begin
            if (dec_left == 0) dec_busy_r <= 1'b0;
            else dec_left <= dec_left - 1;
        end
    end
    assign decoderBusy     = dec_busy_r | dec_hold;
    assign messageRecieved = dec_out;

    // ---------------- checking infrastructure ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int exp_pass = 0;
    int exp_fail = 0;
    int acc_cyc  = 0;

    typedef struct {
        logic [MSG_W-1:0] msg;
        logic             match;
        logic             tmo;
        logic [CW_W-1:0]  rx;
        int               lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [MSG_W-1:0] msg;
        logic [CW_W-1:0]  err;
        logic [MSG_W-1:0] exp_msg;
        logic             exp_match;
        logic             exp_tmo;
        logic             stuck;
        int               hold;
        int               exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one input; called and returns 1 time unit after a rising edge.
    task automatic send(input logic [MSG_W-1:0] m, input logic [CW_W-1:0] e, output int waited);
        cur_msg  = m;
        msg_in   = m;
        err_in   = e;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic get_result(input int hold, input string tag);
        exp_t x;
        int   n;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
            return;
        end
        x = sb.pop_front();
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (x.lat > 0) check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(x.lat));
        check({tag, "_msg"},     64'(out_msg),     64'(x.msg));
        check({tag, "_match"},   64'(out_match),   64'(x.match));
        check({tag, "_timeout"}, 64'(out_timeout), 64'(x.tmo));
        if (!x.tmo) check({tag, "_rxword"}, 64'(recievedWordIn), 64'(x.rx));
        if (hold > 0) begin
            // A competing input offered while the result is pending must not be consumed.
            msg_in = ~cur_msg; in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
            in_valid = 1'b0;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_msg"},   64'(out_msg),   64'(x.msg));
            check({tag, "_hold_ready"}, 64'(in_ready),  64'd0);
            check({tag, "_hold_pass"},  64'(pass_cnt),  64'(exp_pass));
            check({tag, "_hold_fail"},  64'(fail_cnt),  64'(exp_fail));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (x.match) exp_pass = (exp_pass == CNT_MAX) ? CNT_MAX : exp_pass + 1;
        else         exp_fail = (exp_fail == CNT_MAX) ? CNT_MAX : exp_fail + 1;
        check({tag, "_pass_cnt"},  64'(pass_cnt),  64'(exp_pass));
        check({tag, "_fail_cnt"},  64'(fail_cnt),  64'(exp_fail));
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no end of test expected completion");
        $fatal(1, "bench time limit");
    end

    vec_t vt[11];
    int   w;
    exp_t xe;

    initial begin
        // msg, err, exp_msg, match, timeout, stuck_decoder, hold, latency
        vt[0]  = '{36'hBF614A2AC, 60'h0,               36'hBF614A2AC, 1'b1, 1'b0, 1'b0, 0,  15};
        vt[1]  = '{36'hBF614A2AC, 60'h000A00010003000, 36'hBF614A2AC, 1'b1, 1'b0, 1'b0, 0,  15};
        vt[2]  = '{36'hBF614A2AC, 60'h000A00015003000, 36'hBE31492AC, 1'b0, 1'b0, 1'b0, 0,  15};
        vt[3]  = '{36'h123456789, 60'h0,               36'h0,         1'b0, 1'b1, 1'b1, 0,  19};
        vt[4]  = '{36'h0FEDCBA98, 60'h0,               36'h0FEDCBA98, 1'b1, 1'b0, 1'b0, 10, 15};
        vt[5]  = '{36'hFFFFFFFFF, 60'hFFF000000000000, 36'hFFFFFFFFF, 1'b1, 1'b0, 1'b0, 0,  15};
        vt[6]  = '{36'h000000000, 60'h00000000000000F, 36'h000000000, 1'b1, 1'b0, 1'b0, 0,  15};
        vt[7]  = '{36'h5A5A5A5A5, 60'h0,               36'h5A5A5A5A5, 1'b1, 1'b0, 1'b0, 0,  15};
        vt[8]  = '{36'hA5A5A5A5A, 60'h00000000F00F00F, 36'hA5A5A5A5A, 1'b1, 1'b0, 1'b0, 0,  15};
        vt[9]  = '{36'h13579BDF0, 60'h0,               36'h13579BDF0, 1'b1, 1'b0, 1'b0, 0,  15};
        vt[10] = '{36'h13579BDF0, 60'h0000000000FFFFF, 36'h13576420F, 1'b0, 1'b0, 1'b0, 0,  15};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; msg_in = '0; err_in = '0;
        #12;
        check("rst_in_ready",  64'(in_ready),      64'd0);
        check("rst_out_valid", 64'(out_valid),     64'd0);
        check("rst_enc_tgl",   64'(encodeMessage), 64'd0);
        check("rst_pass_cnt",  64'(pass_cnt),      64'd0);
        check("rst_fail_cnt",  64'(fail_cnt),      64'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rel_in_ready_before_clk", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_in_ready_first_clk", 64'(in_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            dec_hold = vt[i].stuck;
            xe.msg   = vt[i].exp_msg;
            xe.match = vt[i].exp_match;
            xe.tmo   = vt[i].exp_tmo;
            xe.rx    = enc_model(vt[i].msg) ^ vt[i].err;
            xe.lat   = vt[i].exp_lat;
            sb.push_back(xe);
            send(vt[i].msg, vt[i].err, w);
            get_result(vt[i].hold, $sformatf("v%0d", i));
            dec_hold = 1'b0;
        end

        // Encoder busy already high in IDLE: accepted at once, ENC_WAIT absorbs it.
        enc_hold = 1'b1;
        xe = '{36'h2468ACE13, 1'b1, 1'b0, enc_model(36'h2468ACE13), 0};
        sb.push_back(xe);
        send(36'h2468ACE13, 60'h0, w);
        check("idle_busy_wait", 64'(w), 64'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("idle_busy_no_result", 64'(out_valid), 64'd0);
        enc_hold = 1'b0;
        get_result(0, "idle_busy");

        // Reset asserted while in ENC_WAIT aborts silently and clears everything at once.
        send(36'h987654321, 60'h0, w);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready),       64'd0);
        check("mid_rst_enc_tgl",  64'(encodeMessage),  64'd0);
        check("mid_rst_dec_tgl",  64'(decodeMessage),  64'd0);
        check("mid_rst_rxword",   64'(recievedWordIn), 64'd0);
        check("mid_rst_out_msg",  64'(out_msg),        64'd0);
        check("mid_rst_valid",    64'(out_valid),      64'd0);
        check("mid_rst_pass_cnt", 64'(pass_cnt),       64'd0);
        check("mid_rst_fail_cnt", 64'(fail_cnt),       64'd0);
        exp_pass = 0; exp_fail = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_idle", 64'(in_ready), 64'd1);
        xe = '{36'hBF614A2AC, 1'b1, 1'b0, enc_model(36'hBF614A2AC), 15};
        sb.push_back(xe);
        send(36'hBF614A2AC, 60'h0, w);
        get_result(0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
